// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB bridge: one AHB transfer becomes one APB transfer.
// All bus-facing outputs are registered; unsupported sizes produce a two-cycle ERROR response.
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic                  PWRITE,
  output logic [HDATA_SIZE-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [HDATA_SIZE-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  state_t state_r;
  logic   accept;
  logic   unused_bits;

  function automatic logic [3:0] pstrb_for(input logic write, input logic [2:0] size,
                                           input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    if (write) begin
      case (size)
        3'b000:  strb = 4'b0001 << addr;
        3'b001:  strb = 4'b0011 << {addr[1], 1'b0};
        3'b010:  strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end else begin
      strb = 4'b0000;
    end
    return strb;
  endfunction

  function automatic logic [2:0] pprot_for(input logic [3:0] prot);
    return {~prot[0], 1'b1, prot[1]};
  endfunction

  assign accept = HSEL & HREADY & HTRANS[1];

  // Burst, lock, HTRANS[0], upper address and cacheability bits carry no meaning for APB.
  assign unused_bits = ^{HBURST, HMASTLOCK, HADDR, HPROT[3:2], HTRANS[0]};

  // Bridge sequencer: state and every registered bus output.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r   <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      HRDATA    <= {HDATA_SIZE{1'b0}};
      PADDR     <= {PADDR_SIZE{1'b0}};
      PWDATA    <= {HDATA_SIZE{1'b0}};
      PSTRB     <= 4'b0000;
      PPROT     <= 3'b000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          PENABLE <= 1'b0;
          if (accept) begin
            PADDR  <= HADDR[PADDR_SIZE-1:0];
            PWRITE <= HWRITE;
            PSTRB  <= pstrb_for(HWRITE, HSIZE, HADDR[1:0]);
            PPROT  <= pprot_for(HPROT);
            HREADYOUT <= 1'b0;
            if (HSIZE > 3'd2) begin
              state_r <= ERR1;
              HRESP   <= 1'b1;
              PSEL    <= 1'b0;
            end else if (HWRITE) begin
              state_r <= WDATA;
              HRESP   <= 1'b0;
              PSEL    <= 1'b0;
            end else begin
              state_r <= SETUP;
              HRESP   <= 1'b0;
              PSEL    <= 1'b1;
            end
          end else begin
            state_r   <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            PSEL      <= 1'b0;
          end
        end
        WDATA: begin
          // HWDATA is only valid in the data phase, one cycle after the address.
          PWDATA  <= HWDATA;
          PSEL    <= 1'b1;
          state_r <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              state_r <= ERR1;
              HRESP   <= 1'b1;
            end else begin
              state_r   <= DONE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!PWRITE) begin
                HRDATA <= PRDATA;
              end else begin
                HRDATA <= HRDATA;
              end
            end
          end else begin
            state_r <= ACCESS;
          end
        end
        ERR1: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
          state_r   <= ERR2;
        end
        ERR2: begin
          // Any address phase seen here is deliberately dropped.
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed bench for ahb3lite_apb_bridge: hand-computed expectations, sampled 1 ns after HCLK rise.
module tb_ahb3lite_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;

  ahb3lite_apb_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [3:0] prot);
    HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HPROT = prot; HTRANS = 2'b10;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'h0; HTRANS = 2'b00; HMASTLOCK = 1'b0;
    HREADY = 1'b1; PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
    step(); step();
    HRESET = 1'b0;
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp",     {31'd0, HRESP},     32'd0);
    chk("rst_psel",      {31'd0, PSEL},      32'd0);
    chk("rst_penable",   {31'd0, PENABLE},   32'd0);
    chk("rst_pwrite",    {31'd0, PWRITE},    32'd0);
    chk("rst_hrdata",    HRDATA,             32'd0);
    chk("rst_paddr",     {16'd0, PADDR},     32'd0);
    chk("rst_pwdata",    PWDATA,             32'd0);
    chk("rst_pstrb",     {28'd0, PSTRB},     32'd0);
    chk("rst_pprot",     {29'd0, PPROT},     32'd0);

    // BUSY while selected: zero-wait OKAY, no APB activity
    HSEL = 1'b1; HTRANS = 2'b01;
    step();
    chk("busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("busy_psel",      {31'd0, PSEL},      32'd0);
    chk("busy_hresp",     {31'd0, HRESP},     32'd0);

    // Word read, PREADY=1
    PRDATA = 32'hDEADBEEF;
    addr_phase(32'h0000_1234, 1'b0, 3'd2, 4'b0011);
    step();
    HTRANS = 2'b00;
    chk("rd_setup_psel",    {31'd0, PSEL},      32'd1);
    chk("rd_setup_penable", {31'd0, PENABLE},   32'd0);
    chk("rd_setup_hready",  {31'd0, HREADYOUT}, 32'd0);
    chk("rd_paddr",         {16'd0, PADDR},     32'h1234);
    chk("rd_pstrb",         {28'd0, PSTRB},     32'd0);
    chk("rd_pwrite",        {31'd0, PWRITE},    32'd0);
    chk("rd_pprot",         {29'd0, PPROT},     32'b011);
    step();
    chk("rd_access_penable", {31'd0, PENABLE},   32'd1);
    chk("rd_access_hready",  {31'd0, HREADYOUT}, 32'd0);
    step();
    chk("rd_done_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("rd_done_hresp",  {31'd0, HRESP},     32'd0);
    chk("rd_hrdata",      HRDATA,             32'hDEADBEEF);
    chk("rd_done_psel",   {31'd0, PSEL},      32'd0);
    step();
    chk("rd_idle_hready", {31'd0, HREADYOUT}, 32'd1);

    // Byte write to lane 3
    addr_phase(32'h0000_0003, 1'b1, 3'd0, 4'b0010);
    step();
    HTRANS = 2'b00; HWDATA = 32'hAA000000;
    chk("wr_wdata_hready", {31'd0, HREADYOUT}, 32'd0);
    chk("wr_wdata_psel",   {31'd0, PSEL},      32'd0);
    step();
    HWDATA = 32'h0;
    chk("wr_setup_psel", {31'd0, PSEL},   32'd1);
    chk("wr_pwdata",     PWDATA,          32'hAA000000);
    chk("wr_pstrb",      {28'd0, PSTRB},  32'b1000);
    chk("wr_pwrite",     {31'd0, PWRITE}, 32'd1);
    chk("wr_pprot",      {29'd0, PPROT},  32'b111);
    step();
    chk("wr_access_hready", {31'd0, HREADYOUT}, 32'd0);
    step();
    chk("wr_done_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("wr_hrdata_kept", HRDATA,             32'hDEADBEEF);
    step();

    // Halfword write with three wait states
    PREADY = 1'b0;
    addr_phase(32'h0000_0002, 1'b1, 3'd1, 4'b0001);
    step();
    HTRANS = 2'b00; HWDATA = 32'h12345678;
    step();
    HWDATA = 32'h0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ws_psel",    {31'd0, PSEL},      32'd1);
      chk("ws_penable", {31'd0, PENABLE},   32'd1);
      chk("ws_paddr",   {16'd0, PADDR},     32'h0002);
      chk("ws_pwdata",  PWDATA,             32'h12345678);
      chk("ws_pstrb",   {28'd0, PSTRB},     32'b1100);
      chk("ws_hready",  {31'd0, HREADYOUT}, 32'd0);
      step();
    end
    PREADY = 1'b1;
    chk("ws_last_hready", {31'd0, HREADYOUT}, 32'd0);
    step();
    chk("ws_done_hready", {31'd0, HREADYOUT}, 32'd1);
    step();

    // PSLVERR on a read, plus an address phase in ERR2 that must be ignored
    PSLVERR = 1'b1; PRDATA = 32'h5555_AAAA;
    addr_phase(32'h0000_0010, 1'b0, 3'd2, 4'b0000);
    step();
    HTRANS = 2'b00;
    step(); step();
    PSLVERR = 1'b0;
    chk("err1_hready", {31'd0, HREADYOUT}, 32'd0);
    chk("err1_hresp",  {31'd0, HRESP},     32'd1);
    chk("err1_psel",   {31'd0, PSEL},      32'd0);
    step();
    chk("err2_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("err2_hresp",  {31'd0, HRESP},     32'd1);
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    chk("err_idle_psel",   {31'd0, PSEL},      32'd0);
    chk("err_idle_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("err_idle_hresp",  {31'd0, HRESP},     32'd0);
    chk("err_hrdata_kept", HRDATA,             32'hDEADBEEF);
    step();
    chk("err2_ignored_psel", {31'd0, PSEL}, 32'd0);

    // Unsupported size: error without APB transfer
    addr_phase(32'h0000_0040, 1'b0, 3'd3, 4'b0000);
    step();
    HTRANS = 2'b00;
    chk("sz3_err1_hready", {31'd0, HREADYOUT}, 32'd0);
    chk("sz3_err1_hresp",  {31'd0, HRESP},     32'd1);
    chk("sz3_err1_psel",   {31'd0, PSEL},      32'd0);
    step();
    chk("sz3_err2_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("sz3_err2_hresp",  {31'd0, HRESP},     32'd1);
    chk("sz3_err2_psel",   {31'd0, PSEL},      32'd0);
    step();
    chk("sz3_idle_hresp", {31'd0, HRESP}, 32'd0);
    chk("sz3_idle_psel",  {31'd0, PSEL},  32'd0);

    // Back-to-back reads, then reset in ACCESS
    PRDATA = 32'hCAFEF00D;
    addr_phase(32'h0000_0020, 1'b0, 3'd2, 4'b0000);
    step();
    HTRANS = 2'b00;
    step(); step();
    chk("b2b_done_hready", {31'd0, HREADYOUT}, 32'd1);
    chk("b2b_hrdata",      HRDATA,             32'hCAFEF00D);
    addr_phase(32'h0000_0024, 1'b0, 3'd2, 4'b0000);
    step();
    HTRANS = 2'b00;
    chk("b2b_psel",   {31'd0, PSEL},      32'd1);
    chk("b2b_paddr",  {16'd0, PADDR},     32'h0024);
    chk("b2b_hready", {31'd0, HREADYOUT}, 32'd0);
    step();
    chk("b2b_access_penable", {31'd0, PENABLE}, 32'd1);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    chk("rstacc_psel",    {31'd0, PSEL},      32'd0);
    chk("rstacc_penable", {31'd0, PENABLE},   32'd0);
    chk("rstacc_hready",  {31'd0, HREADYOUT}, 32'd1);
    chk("rstacc_hresp",   {31'd0, HRESP},     32'd0);
    chk("rstacc_hrdata",  HRDATA,             32'd0);
    step();
    chk("rstacc_idle_psel",   {31'd0, PSEL},      32'd0);
    chk("rstacc_idle_hready", {31'd0, HREADYOUT}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb3lite_apb_bridge.md
AHB3LITE_APB_BRIDGE -- requirements
Module: ahb3lite_apb_bridge

Interface
REQ-001 The block SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 The block SHALL have parameter HDATA_SIZE, default 32, AHB/APB data width (32 only).
REQ-003 The block SHALL have parameter PADDR_SIZE, default 16, APB address width (<= HADDR_SIZE).
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with these ports:
  HCLK  in  1  clock, all logic on rising edge
  HRESET  in  1  synchronous active-high reset
  HSEL  in  1  slave select from interconnect master port
  HADDR  in  HADDR_SIZE  address
  HWDATA  in  HDATA_SIZE  write data, valid in data phase
  HRDATA  out  HDATA_SIZE  read data, registered
  HWRITE  in  1  1 = write
  HSIZE  in  3  transfer size
  HBURST  in  3  burst type, ignored
  HPROT  in  4  protection
  HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
  HMASTLOCK  in  1  ignored
  HREADY  in  1  bus HREADY
  HREADYOUT  out  1  slave ready, registered
  HRESP  out  1  1 = ERROR, registered
  PSEL  out  1  APB select
  PENABLE  out  1  APB enable
  PADDR  out  PADDR_SIZE  HADDR[PADDR_SIZE-1:0] of the captured address phase
  PWRITE  out  1  APB direction
  PWDATA  out  HDATA_SIZE  APB write data
  PSTRB  out  4  byte strobes
  PPROT  out  3  APB protection
  PRDATA  in  HDATA_SIZE  APB read data
  PREADY  in  1  APB ready
  PSLVERR  in  1  APB error

Function
REQ-005 Accept SHALL be defined as HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ), sampled only in states IDLE and DONE.
REQ-006 FSM states SHALL be IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-007 On accept, the block SHALL register HADDR, HWRITE, HSIZE and HPROT; next state SETUP (read), WDATA (write), or ERR1 if HSIZE > 2.
REQ-008 WDATA: HREADYOUT=0, PSEL=0; the block SHALL capture HWDATA into PWDATA; next state SETUP.
REQ-009 SETUP: PSEL=1, PENABLE=0, HREADYOUT=0; next state ACCESS.
REQ-010 ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0; the block SHALL hold all P* outputs stable while PREADY=0.
REQ-011 ACCESS & PREADY & !PSLVERR: HRDATA<=PRDATA (reads only; unchanged on writes); next state DONE.
REQ-012 ACCESS & PREADY & PSLVERR: next state ERR1.
REQ-013 DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0; next state per REQ-007 if accept, else IDLE.
REQ-014 ERR1: HREADYOUT=0, HRESP=1, PSEL=0; next state ERR2. ERR2: HREADYOUT=1, HRESP=1; next state IDLE, and the block SHALL ignore any address phase presented in ERR2.
REQ-015 IDLE: HREADYOUT=1, HRESP=0, PSEL=0; HSEL with HTRANS IDLE or BUSY SHALL give a zero-wait OKAY and remain in IDLE.
REQ-016 PSTRB SHALL be 0 on reads. On writes it SHALL be: byte 4'b0001<<HADDR[1:0]; half 4'b0011<<{HADDR[1],1'b0}; word 4'b1111.
REQ-017 PPROT SHALL be {~HPROT[0], 1'b1, HPROT[1]}.
REQ-018 Latency from accept to HREADYOUT=1 SHALL be 3 cycles for a read and 4 for a write, each with PREADY=1; each PREADY=0 cycle SHALL add 1.
REQ-019 An unsupported HSIZE SHALL produce no APB transfer (PSEL never asserted).

Reset
REQ-020 With HRESET=1 at a rising edge, the block SHALL go to IDLE and set: HREADYOUT=1; HRESP=0; PSEL, PENABLE and PWRITE 0; HRDATA, PADDR, PWDATA, PSTRB and PPROT 0.
REQ-021 A reset during WDATA, SETUP, ACCESS or ERR states SHALL abort the transfer: PSEL=0 on the next cycle, and no DONE or error response is produced.

Verification
REQ-022 Read: HADDR=0x0000_1234, HSIZE=2, PRDATA=0xDEADBEEF, PREADY=1 -> PADDR=0x1234, PSTRB=0, HREADYOUT low 2 cycles then 1, HRDATA=0xDEADBEEF, HRESP=0.
REQ-023 Write byte: HADDR=0x...0003, HSIZE=0, HWDATA=0xAA000000 -> PSTRB=4'b1000, PWDATA=0xAA000000, PWRITE=1, HREADYOUT high on cycle 4.
REQ-024 Wait states: PREADY=0 for 3 ACCESS cycles -> PSEL, PENABLE, PADDR and PWDATA stable, completion delayed by 3 cycles.
REQ-025 Error: PSLVERR=1 with PREADY=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); HSIZE=3 -> same two-cycle error with PSEL never 1.
REQ-026 Back-to-back and reset: second NONSEQ accepted in DONE -> PSEL=1 on the next cycle. HRESET asserted in ACCESS -> next cycle PSEL=0, HREADYOUT=1, state IDLE.
